// File: rtl/alu_execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_execute_stage_pkg
//   Shared definitions for the ALU control decoder and the execute stage:
//   - 3-bit ALU control encodings (1xx codes are executed as ADD)
//   - default operand and register-index widths
//   - execute-stage state type
// -----------------------------------------------------------------------------
package alu_execute_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MOVE = 3'b010;
  localparam logic [2:0] ALU_SWAP = 3'b011;

  // RUN: normal issue; SWAP2: second SWAP writeback beat still pending
  typedef enum logic {
    RUN   = 1'b0,
    SWAP2 = 1'b1
  } exec_state_t;

endpackage

// File: rtl/alu_execute_stage_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Combinational ALU for the execute stage.
//   Ports:
//     alu_control  in   3-bit operation code (ADD/SUB/MOVE/SWAP, 1xx = ADD)
//     op_a, op_b   in   operands (rd value, rs value)
//     result       out  ADD/1xx: a+b, SUB: a-b, MOVE/SWAP: b (all modulo 2^DATA_W)
//   Optional (macro ALU_FLAGS_EN):
//     flag_zero    out  result == 0
//     flag_neg     out  result MSB
//     flag_ovf     out  signed overflow of ADD/SUB, 0 for MOVE/SWAP
// -----------------------------------------------------------------------------
module alu_core
  import alu_execute_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]               alu_control,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  output logic signed [DATA_W-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic                     flag_zero,
  output logic                     flag_neg,
  output logic                     flag_ovf
`endif
);

  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    result = sum;
    case (alu_control)
      ALU_SUB:            result = diff;
      ALU_MOVE, ALU_SWAP: result = op_b;
      default:            result = sum;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Overflow: ADD when equal-signed operands give a differently signed sum;
  // SUB when opposite-signed operands give a result whose sign differs from a.
  always_comb begin
    flag_ovf = 1'b0;
    case (alu_control)
      ALU_SUB:            flag_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                                     (diff[DATA_W-1] != op_a[DATA_W-1]);
      ALU_MOVE, ALU_SWAP: flag_ovf = 1'b0;
      default:            flag_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                                     (sum[DATA_W-1] != op_a[DATA_W-1]);
    endcase
  end

  assign flag_zero = (result == '0);
  assign flag_neg  = result[DATA_W-1];
`endif

endmodule

// File: rtl/alu_execute_stage.sv
// -----------------------------------------------------------------------------
// alu_execute_stage
//   Execute stage: accepts a decoded instruction through in_valid/in_ready,
//   computes the result with alu_core and presents one register writeback beat
//   through out_valid/out_ready. SWAP produces two beats (rd <= op_b, then
//   rs <= op_a); issue is stalled while the second beat is pending.
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     in_valid / in_ready      issue handshake
//     alu_control, op_a, op_b  operation code and operand values (rd, rs)
//     rd, rs                   destination / source register indices
//     out_valid / out_ready    writeback handshake
//     out_reg, out_data        register index and value to write
//   Optional (macro ALU_FLAGS_EN): flag_zero, flag_neg, flag_ovf registered
//   alongside out_data.
// -----------------------------------------------------------------------------
module alu_execute_stage
  import alu_execute_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               alu_control,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic [REG_W-1:0]         rd,
  input  logic [REG_W-1:0]         rs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_W-1:0]         out_reg,
  output logic signed [DATA_W-1:0] out_data
`ifdef ALU_FLAGS_EN
  ,
  output logic                     flag_zero,
  output logic                     flag_neg,
  output logic                     flag_ovf
`endif
);

  exec_state_t              state_p1;
  logic                     vld_p1;
  logic [REG_W-1:0]         reg_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic [REG_W-1:0]         swap_rs_p1;
  logic signed [DATA_W-1:0] swap_a_p1;
  logic signed [DATA_W-1:0] alu_res_p0;
  logic                     can_load;
  logic                     accept;

  // ---- stage p0: operands in, combinational ALU ----
`ifdef ALU_FLAGS_EN
  logic zero_p0, neg_p0, ovf_p0;
  logic zero_p1, neg_p1, ovf_p1;
`endif

  alu_core #(
    .DATA_W(DATA_W)
  ) u_alu_core (
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .result     (alu_res_p0)
`ifdef ALU_FLAGS_EN
    ,
    .flag_zero  (zero_p0),
    .flag_neg   (neg_p0),
    .flag_ovf   (ovf_p0)
`endif
  );

  assign can_load = !vld_p1 || out_ready;
  assign in_ready = (state_p1 == RUN) && can_load;
  assign accept   = in_valid && in_ready;

  // ---- stage p1: writeback beat register ----
  // When a beat is stalled (valid && !ready) can_load is low, so neither
  // branch below touches the beat registers and out_* holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1   <= RUN;
      vld_p1     <= 1'b0;
      reg_p1     <= '0;
      data_p1    <= '0;
      swap_rs_p1 <= '0;
      swap_a_p1  <= '0;
`ifdef ALU_FLAGS_EN
      zero_p1    <= 1'b0;
      neg_p1     <= 1'b0;
      ovf_p1     <= 1'b0;
`endif
    end else begin
      case (state_p1)
        RUN: begin
          if (accept) begin
            vld_p1  <= 1'b1;
            reg_p1  <= rd;
            data_p1 <= alu_res_p0;
`ifdef ALU_FLAGS_EN
            zero_p1 <= zero_p0;
            neg_p1  <= neg_p0;
            ovf_p1  <= ovf_p0;
`endif
            if (alu_control == ALU_SWAP) begin
              swap_rs_p1 <= rs;
              swap_a_p1  <= op_a;
              state_p1   <= SWAP2;
            end
          end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        SWAP2: begin
          if (can_load) begin
            vld_p1   <= 1'b1;
            reg_p1   <= swap_rs_p1;
            data_p1  <= swap_a_p1;
`ifdef ALU_FLAGS_EN
            zero_p1  <= (swap_a_p1 == '0);
            neg_p1   <= swap_a_p1[DATA_W-1];
            ovf_p1   <= 1'b0;
`endif
            state_p1 <= RUN;
          end
        end
        default: state_p1 <= RUN;
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_reg   = reg_p1;
  assign out_data  = data_p1;
`ifdef ALU_FLAGS_EN
  assign flag_zero = zero_p1;
  assign flag_neg  = neg_p1;
  assign flag_ovf  = ovf_p1;
`endif

endmodule

// File: tb/tb_alu_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_execute_stage
//   Directed scenarios plus a randomized run against a queue-based reference
//   model of the writeback beat stream. Define ALU_FLAGS_EN to also check flags.
// -----------------------------------------------------------------------------
module tb_alu_execute_stage;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs;
  logic              out_valid;
  logic              out_ready;
  logic [REG_W-1:0]  out_reg;
  logic [DATA_W-1:0] out_data;
`ifdef ALU_FLAGS_EN
  logic              flag_zero;
  logic              flag_neg;
  logic              flag_ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
    logic              ovf;
  } beat_t;

  always #5 clk = ~clk;

  alu_execute_stage #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .rd         (rd),
    .rs         (rs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_reg    (out_reg),
    .out_data   (out_data)
`ifdef ALU_FLAGS_EN
    ,
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_ovf   (flag_ovf)
`endif
  );

  // Reference: result by plain integer arithmetic.
  function automatic logic [DATA_W-1:0] ref_result(input logic [2:0] c,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    int unsigned r;
    case (c)
      3'd1:       r = int'(a) - int'(b);
      3'd2, 3'd3: r = int'(b);
      default:    r = int'(a) + int'(b);
    endcase
    return r[DATA_W-1:0];
  endfunction

  // Reference: signed overflow when the exact signed result is out of range.
  function automatic logic ref_ovf(input logic [2:0] c,
                                   input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (c)
      3'd1:       r = sa - sb;
      3'd2, 3'd3: return 1'b0;
      default:    r = sa + sb;
    endcase
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [REG_W-1:0] d, input logic [REG_W-1:0] s);
    in_valid    = v;
    alu_control = c;
    op_a        = a;
    op_b        = b;
    rd          = d;
    rs          = s;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 16'h1234, 16'h0001, 4'd9, 4'd0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold_valid got %0b want 0", out_valid);
    end
    reset = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_reg !== 4'h0) begin
      errors++; $display("FAIL reset_outputs got v=%0b r=%0h d=%0h want 0/0/0",
                         out_valid, out_reg, out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({flag_zero, flag_neg, flag_ovf} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %03b want 000", {flag_zero, flag_neg, flag_ovf});
    end
`endif
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 16'h7FFF, 16'h0001, 4'd3, 4'd0);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd3 || out_data !== 16'h8000) begin
      errors++; $display("FAIL add_result got v=%0b r=%0d d=%0h want 1/3/8000",
                         out_valid, out_reg, out_data);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (flag_ovf !== 1'b1 || flag_neg !== 1'b1 || flag_zero !== 1'b0) begin
      errors++; $display("FAIL add_flags got z=%0b n=%0b o=%0b want 0/1/1",
                         flag_zero, flag_neg, flag_ovf);
    end
`endif
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 16'd5, 16'd5, 4'd7, 4'd0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd7 || out_data !== 16'h0) begin
      errors++; $display("FAIL sub_zero got v=%0b r=%0d d=%0h want 1/7/0",
                         out_valid, out_reg, out_data);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (flag_zero !== 1'b1 || flag_ovf !== 1'b0) begin
      errors++; $display("FAIL sub_flags got z=%0b o=%0b want 1/0", flag_zero, flag_ovf);
    end
`endif
    drive(1'b1, 3'b110, 16'd2, 16'd3, 4'd8, 4'd0);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    checks++;
    if (out_reg !== 4'd8 || out_data !== 16'd5) begin
      errors++; $display("FAIL code110_add got r=%0d d=%0h want 8/5", out_reg, out_data);
    end
    drive(1'b1, 3'b001, 16'h0003, 16'h0005, 4'd2, 4'd0);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    checks++;
    if (out_data !== 16'hFFFE) begin
      errors++; $display("FAIL sub_wrap got %0h want fffe", out_data);
    end
    tick();
  endtask

  task automatic test_swap();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 16'hAAAA, 16'h5555, 4'd1, 4'd2);
    tick();
    // MOVE presented immediately; must wait out the second SWAP beat
    drive(1'b1, 3'b010, 16'h0000, 16'h1234, 4'd7, 4'd0);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd1 || out_data !== 16'h5555) begin
      errors++; $display("FAIL swap_beat1 got v=%0b r=%0d d=%0h want 1/1/5555",
                         out_valid, out_reg, out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL swap_stall got in_ready=%0b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd2 || out_data !== 16'hAAAA) begin
      errors++; $display("FAIL swap_beat2 got v=%0b r=%0d d=%0h want 1/2/aaaa",
                         out_valid, out_reg, out_data);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (flag_ovf !== 1'b0 || flag_neg !== 1'b1 || flag_zero !== 1'b0) begin
      errors++; $display("FAIL swap_flags got z=%0b n=%0b o=%0b want 0/1/0",
                         flag_zero, flag_neg, flag_ovf);
    end
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL swap_resume got in_ready=%0b want 1", in_ready);
    end
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd7 || out_data !== 16'h1234) begin
      errors++; $display("FAIL swap_next_move got v=%0b r=%0d d=%0h want 1/7/1234",
                         out_valid, out_reg, out_data);
    end
    tick();
  endtask

  task automatic test_swap_same_reg();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 16'h1111, 16'h2222, 4'd4, 4'd4);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    checks++;
    if (out_reg !== 4'd4 || out_data !== 16'h2222) begin
      errors++; $display("FAIL swap_same_b1 got r=%0d d=%0h want 4/2222", out_reg, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd4 || out_data !== 16'h1111) begin
      errors++; $display("FAIL swap_same_b2 got v=%0b r=%0d d=%0h want 1/4/1111",
                         out_valid, out_reg, out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 16'h0000, 16'hBEEF, 4'd5, 4'd0);
    tick();
    drive(1'b1, 3'b000, 16'd1, 16'd2, 4'd6, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 4'd5 || out_data !== 16'hBEEF || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%0b r=%0d d=%0h rdy=%0b want 1/5/beef/0",
                           i, out_valid, out_reg, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready);
    end
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 4'd6 || out_data !== 16'd3) begin
      errors++; $display("FAIL bp_no_bubble got v=%0b r=%0d d=%0h want 1/6/3",
                         out_valid, out_reg, out_data);
    end
    tick();
  endtask

  task automatic test_reset_in_swap2();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 16'hCAFE, 16'h0BAD, 4'd9, 4'd10);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL swap2_reset_valid got %0b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL swap2_reset_no_beat2 got v=%0b rdy=%0b want 0/1",
                         out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    beat_t             q[$];
    beat_t             b;
    logic              pend;
    logic              held;
    logic [REG_W-1:0]  hreg;
    logic [DATA_W-1:0] hdata;
    logic              canl;
    logic              exp_rdy;
    logic              acc;
    pend = 1'b0;
    held = 1'b0;
    hreg = '0;
    hdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (held) begin
          if (out_reg !== hreg || out_data !== hdata) begin
            errors++; $display("FAIL rnd_stable cyc=%0d got r=%0d d=%0h want r=%0d d=%0h",
                               cyc, out_reg, out_data, hreg, hdata);
          end
        end else if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat cyc=%0d got r=%0d d=%0h want none",
                             cyc, out_reg, out_data);
        end else begin
          b = q.pop_front();
          if (out_reg !== b.r || out_data !== b.d) begin
            errors++; $display("FAIL rnd_beat cyc=%0d got r=%0d d=%0h want r=%0d d=%0h",
                               cyc, out_reg, out_data, b.r, b.d);
          end
`ifdef ALU_FLAGS_EN
          checks++;
          if (flag_zero !== (b.d == '0) || flag_neg !== b.d[DATA_W-1] || flag_ovf !== b.ovf) begin
            errors++; $display("FAIL rnd_flags cyc=%0d got %0b%0b%0b want %0b%0b%0b", cyc,
                               flag_zero, flag_neg, flag_ovf, (b.d == '0), b.d[DATA_W-1], b.ovf);
          end
`endif
        end
      end
      if (cyc < 2900) begin
        drive(($urandom % 4) != 0, 3'($urandom), 16'($urandom), 16'($urandom),
              4'($urandom), 4'($urandom));
        out_ready = ($urandom % 4) != 0;
      end else begin
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
        out_ready = 1'b1;
      end
      #1;
      canl    = !out_valid || out_ready;
      exp_rdy = !pend && canl;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_in_ready cyc=%0d got %0b want %0b", cyc, in_ready, exp_rdy);
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        b.r = rd; b.d = ref_result(alu_control, op_a, op_b); b.ovf = ref_ovf(alu_control, op_a, op_b);
        q.push_back(b);
        if (alu_control == 3'b011) begin
          b.r = rs; b.d = op_a; b.ovf = 1'b0;
          q.push_back(b);
        end
      end
      if (pend && canl) pend = 1'b0;
      else if (acc && alu_control == 3'b011) pend = 1'b1;
      held  = out_valid && !out_ready;
      hreg  = out_reg;
      hdata = out_data;
      tick();
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rnd_drain got pending=%0d v=%0b want 0/0", q.size(), out_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0);
    test_reset();
    test_add();
    test_sub();
    test_swap();
    test_swap_same_reg();
    test_backpressure();
    test_reset_in_swap2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
